// File: rtl/fir_mac.sv
// ============================================================================
//  Module      : fir_mac
//  Description : 8-tap FIR multiply-accumulate engine for one audio stream.
//                Walks an external registered coefficient store (get_tap,
//                1-cycle read latency) through tapnum, keeps the sample delay
//                line, and emits one saturated Q1.15 result per accepted
//                sample, 10 clocks after the accept edge.
//  Config      : FIR_ROUND_EN - when defined, round half up (+0.5 LSB)
//                before the final >>>15; otherwise truncate toward -inf.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int ACCW  = 35
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 ready,
  input  logic [3:0]           filter_sel,
  output logic [3:0]           filterNum,
  output logic [2:0]           tapnum,
  input  logic signed [DW-1:0] tapcoeff,
  output logic signed [DW-1:0] sample_out,
  output logic                 out_valid,
  output logic                 overrun
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Sequencer count at which the last product has been accumulated
  localparam logic [3:0] C_CNT_LAST = 4'd9;
  // First and last counts that carry a valid coefficient/sample pair
  localparam logic [3:0] C_CNT_MAC_FIRST = 4'd1;
  localparam logic [3:0] C_CNT_MAC_LAST  = 4'd8;
  localparam logic [2:0] C_TAP_LAST      = 3'(NTAPS - 1);

  // Output clamp limits expressed at accumulator width
  localparam logic signed [ACCW-1:0] C_YMAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] C_YMIN = ~C_YMAX;
`ifdef FIR_ROUND_EN
  // Half an output LSB in accumulator units
  localparam logic signed [ACCW-1:0] C_HALF = ACCW'(64'sd1 <<< (DW - 2));
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q,   cnt_d;
  logic [2:0]             tap_q,   tap_d;
  logic [3:0]             filt_q,  filt_d;
  logic signed [ACCW-1:0] acc_q,   acc_d;
  logic signed [DW-1:0]   sout_q,  sout_d;
  logic                   ovalid_q, ovalid_d;
  logic                   ovr_q,   ovr_d;
  logic signed [DW-1:0]   x_q [NTAPS];

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic                   w_ready;
  logic                   w_shift_en;
  logic                   w_mac_en;
  logic [2:0]             w_midx;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_acc_adj;
  logic signed [ACCW-1:0] w_y;
  logic signed [DW-1:0]   w_sat;

  assign w_ready = (state_q == S_IDLE) || (state_q == S_DONE);

  // The coefficient on tapcoeff belongs to the tap requested one cycle ago,
  // so the matching sample is x[cnt-1].
  assign w_mac_en   = (state_q == S_RUN) &&
                      (cnt_q >= C_CNT_MAC_FIRST) && (cnt_q <= C_CNT_MAC_LAST);
  assign w_midx     = 3'(cnt_q - 4'd1);
  assign w_prod     = tapcoeff * x_q[w_midx];
  assign w_prod_ext = {{(ACCW - 2*DW){w_prod[2*DW-1]}}, w_prod};

`ifdef FIR_ROUND_EN
  assign w_acc_adj = acc_q + C_HALF;
`else
  assign w_acc_adj = acc_q;
`endif

  assign w_y = w_acc_adj >>> (DW - 1);

  // Clamp the rescaled sum into the Q1.15 output range
  always_comb begin
    w_sat = w_y[DW-1:0];
    if (w_y > C_YMAX) begin
      w_sat = C_YMAX[DW-1:0];
    end else if (w_y < C_YMIN) begin
      w_sat = C_YMIN[DW-1:0];
    end
  end

  // Next-state logic for the sequencer, accumulator and output stage
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tap_d      = tap_q;
    filt_d     = filt_q;
    acc_d      = acc_q;
    sout_d     = sout_q;
    ovalid_d   = 1'b0;
    w_shift_en = 1'b0;
    ovr_d      = sample_valid & ~w_ready;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (sample_valid) begin
          // Accept: restart the walk over the taps with the new filter
          state_d    = S_RUN;
          cnt_d      = 4'd0;
          tap_d      = 3'd0;
          filt_d     = filter_sel;
          acc_d      = '0;
          w_shift_en = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (w_mac_en) begin
          acc_d = acc_q + w_prod_ext;
        end
        if (cnt_q == C_CNT_LAST) begin
          state_d  = S_DONE;
          sout_d   = w_sat;
          ovalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (tap_q != C_TAP_LAST) begin
            tap_d = tap_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, accumulator and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tap_q    <= '0;
      filt_q   <= '0;
      acc_q    <= '0;
      sout_q   <= '0;
      ovalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tap_q    <= tap_d;
      filt_q   <= filt_d;
      acc_q    <= acc_d;
      sout_q   <= sout_d;
      ovalid_q <= ovalid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Sample delay line; shifts only on an accepted sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (w_shift_en) begin
      for (int i = NTAPS - 1; i > 0; i--) begin
        x_q[i] <= x_q[i-1];
      end
      x_q[0] <= sample_in;
    end
  end

  assign ready      = w_ready;
  assign filterNum  = filt_q;
  assign tapnum     = tap_q;
  assign sample_out = sout_q;
  assign out_valid  = ovalid_q;
  assign overrun    = ovr_q;

endmodule

`default_nettype wire
